// File: rtl/wind_lights_gen_pkg.sv
// Shared types and helpers for the wind-indicator light generator.
package wind_lights_pkg;

  typedef enum logic [1:0] {
    MODE_CALM   = 2'b00,
    MODE_RTOL   = 2'b01,
    MODE_LTOR   = 2'b10,
    MODE_BOUNCE = 2'b11
  } mode_t;

  typedef enum logic [2:0] {
    ST_CALM_A,
    ST_CALM_B,
    ST_LTOR,
    ST_RTOL,
    ST_BOUNCE_UP,
    ST_BOUNCE_DN
  } state_t;

  localparam int MAX_LEDS = 32;

  // One-hot at bit n/2 (integer division); the caller truncates to its width.
  function automatic logic [MAX_LEDS-1:0] center_mask(input int n);
    return MAX_LEDS'(1) << (n / 2);
  endfunction

endpackage

// File: rtl/wind_lights_gen_if.sv
// Control/observation bundle between the switch logic, the generator and the LED register.
interface wind_lights_gen_if #(
  parameter int N_LEDS = 8,
  parameter int DIV_W  = 8
);
  logic              enable;
  logic [1:0]        mode;
  logic [DIV_W-1:0]  step_div;
  logic [N_LEDS-1:0] leds;
  logic              step_pulse;

  modport master (output enable, mode, step_div, input leds, step_pulse);
  modport slave  (input enable, mode, step_div, output leds, step_pulse);
endinterface

// File: rtl/wind_lights_gen_prescaler.sv
// Step-rate divider: one tick every step_div+1 enabled cycles.
// The >= compare makes a lowered step_div take effect on the very next cycle.
module wind_step_prescaler #(
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [DIV_W-1:0] step_div,
  output logic             tick
);
  logic [DIV_W-1:0] cnt;

  assign tick = enable && (cnt >= step_div);

  // Count enabled cycles, restart on tick, freeze while disabled.
  always_ff @(posedge clk) begin
    if (reset)       cnt <= '0;
    else if (tick)   cnt <= '0;
    else if (enable) cnt <= cnt + 1'b1;
  end
endmodule

// File: rtl/wind_lights_gen.sv
// Wind-indicator LED pattern generator: calm blink, sweeps and mode 11.
// Build option: WIND_LIGHTS_BOUNCE_EN makes mode 11 a bounce sweep;
// without it mode 11 holds the current pattern (prescaler keeps running).
//
// state        | meaning
// ST_CALM_A    | leds = centre light only
// ST_CALM_B    | leds = all but centre light
// ST_LTOR      | single light moving left to right (pos decrements)
// ST_RTOL      | single light moving right to left (pos increments)
// ST_BOUNCE_UP | bounce, light moving left (pos increments)
// ST_BOUNCE_DN | bounce, light moving right (pos decrements)
module wind_lights_gen
  import wind_lights_pkg::*;
#(
  parameter int N_LEDS = 8,
  parameter int DIV_W  = 8
) (
  input  logic             clk,
  input  logic             reset,
  wind_lights_gen_if.slave bus
);
  localparam int PW = $clog2(N_LEDS);
  localparam logic [PW-1:0]     POS_MAX    = PW'(N_LEDS - 1);
  localparam logic [N_LEDS-1:0] CENTER     = N_LEDS'(center_mask(N_LEDS));
`ifdef WIND_LIGHTS_BOUNCE_EN
  localparam logic [PW-1:0]     POS_MAX_M1 = PW'(N_LEDS - 2);
`endif

  logic              tick;
  state_t            state_q, state_d;
  logic [PW-1:0]     pos_q, pos_d;
  logic [N_LEDS-1:0] leds_q, leds_d;
  logic              step_pulse_q;

  function automatic logic [N_LEDS-1:0] onehot(input logic [PW-1:0] p);
    return N_LEDS'(1) << p;
  endfunction

  wind_step_prescaler #(.DIV_W(DIV_W)) u_prescaler (
    .clk      (clk),
    .reset    (reset),
    .enable   (bus.enable),
    .step_div (bus.step_div),
    .tick     (tick)
  );

  // Next state, position and LED pattern; everything holds unless tick.
  always_comb begin
    state_d = state_q;
    pos_d   = pos_q;
    leds_d  = leds_q;
    if (tick) begin
      case (mode_t'(bus.mode))
        MODE_CALM: begin
          if (state_q == ST_CALM_A) begin
            state_d = ST_CALM_B;
            leds_d  = ~CENTER;
          end else begin
            state_d = ST_CALM_A;
            leds_d  = CENTER;
          end
        end
        MODE_LTOR: begin
          state_d = ST_LTOR;
          if (state_q != ST_LTOR || pos_q == '0) pos_d = POS_MAX;
          else                                   pos_d = pos_q - 1'b1;
          leds_d = onehot(pos_d);
        end
        MODE_RTOL: begin
          state_d = ST_RTOL;
          if (state_q != ST_RTOL || pos_q == POS_MAX) pos_d = '0;
          else                                        pos_d = pos_q + 1'b1;
          leds_d = onehot(pos_d);
        end
        MODE_BOUNCE: begin
`ifdef WIND_LIGHTS_BOUNCE_EN
          // End lights are shown once per pass: turn around one step early.
          case (state_q)
            ST_BOUNCE_UP: begin
              if (pos_q == POS_MAX) begin
                state_d = ST_BOUNCE_DN;
                pos_d   = POS_MAX_M1;
              end else begin
                pos_d = pos_q + 1'b1;
              end
            end
            ST_BOUNCE_DN: begin
              if (pos_q == '0) begin
                state_d = ST_BOUNCE_UP;
                pos_d   = PW'(1);
              end else begin
                pos_d = pos_q - 1'b1;
              end
            end
            default: begin
              state_d = ST_BOUNCE_UP;
              pos_d   = '0;
            end
          endcase
          leds_d = onehot(pos_d);
`endif
        end
        default: begin
        end
      endcase
    end
  end

  // State, LED and step-pulse registers; reset wins over everything.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_CALM_A;
      pos_q        <= '0;
      leds_q       <= CENTER;
      step_pulse_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pos_q        <= pos_d;
      leds_q       <= leds_d;
      step_pulse_q <= tick;
    end
  end

  assign bus.leds       = leds_q;
  assign bus.step_pulse = step_pulse_q;

endmodule

// File: tb/tb_wind_lights_gen.sv
// Self-checking bench for wind_lights_gen (N_LEDS = 8).
module tb_wind_lights_gen;
  localparam int N = 8;
  localparam logic [N-1:0] C = 8'b0001_0000;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  wind_lights_gen_if #(.N_LEDS(N), .DIV_W(8)) bus ();

  wind_lights_gen #(.N_LEDS(N), .DIV_W(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;
  bit chk_en   = 1'b0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h at %0t", name, got, exp, $time);
  endtask

  // Behavioural model: patterns as rotations/shifts of the LED vector.
  localparam int K_CALM = 0, K_RTOL = 1, K_LTOR = 2, K_BNC = 3;
  logic [N-1:0] m_leds;
  int           m_kind;
  bit           m_up;
  int           m_cnt;
  bit           m_pulse;

  always @(posedge clk) begin
    bit t;
    if (reset) begin
      m_leds = C; m_kind = K_CALM; m_cnt = 0; m_pulse = 0; m_up = 1;
    end else begin
      t = bus.enable && (m_cnt >= int'(bus.step_div));
      m_pulse = t;
      if (t) begin
        m_cnt = 0;
        case (bus.mode)
          2'b00: begin
            if (m_kind == K_CALM) m_leds = (m_leds == C) ? ~C : C;
            else begin m_kind = K_CALM; m_leds = C; end
          end
          2'b10: begin
            if (m_kind != K_LTOR) begin m_kind = K_LTOR; m_leds = 8'h80; end
            else m_leds = {m_leds[0], m_leds[N-1:1]};
          end
          2'b01: begin
            if (m_kind != K_RTOL) begin m_kind = K_RTOL; m_leds = 8'h01; end
            else m_leds = {m_leds[N-2:0], m_leds[N-1]};
          end
          default: begin
`ifdef WIND_LIGHTS_BOUNCE_EN
            if (m_kind != K_BNC) begin m_kind = K_BNC; m_leds = 8'h01; m_up = 1; end
            else if (m_up) begin
              if (m_leds == 8'h80) begin m_up = 0; m_leds = 8'h40; end
              else m_leds = m_leds << 1;
            end else begin
              if (m_leds == 8'h01) begin m_up = 1; m_leds = 8'h02; end
              else m_leds = m_leds >> 1;
            end
`endif
          end
        endcase
      end else if (bus.enable) begin
        m_cnt++;
      end
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      check("model_leds", 32'(bus.leds), 32'(m_leds));
      check("model_pulse", 32'(bus.step_pulse), 32'(m_pulse));
    end
  end

  task automatic wait_step(output int gap);
    gap = 0;
    do begin
      @(negedge clk);
      gap++;
    end while (!bus.step_pulse && gap < 40);
    check("step_seen", 32'(bus.step_pulse), 32'd1);
  endtask

  task automatic expect_steps(input string name, input logic [7:0] seq[], input int exp_gap);
    int g;
    foreach (seq[i]) begin
      wait_step(g);
      check({name, "_leds"}, 32'(bus.leds), 32'(seq[i]));
      check({name, "_gap"}, 32'(g), 32'(exp_gap));
    end
  endtask

  initial begin
    logic [7:0] calm_seq[]  = '{8'hEF, 8'h10, 8'hEF, 8'h10, 8'hEF, 8'h10};
    logic [7:0] sweep_seq[] = '{8'h80, 8'h40, 8'h20, 8'h10, 8'h08, 8'h04,
                                8'h02, 8'h01, 8'h80, 8'h40, 8'h20};
    logic [7:0] rtol_seq[]  = '{8'h01, 8'h02};
`ifdef WIND_LIGHTS_BOUNCE_EN
    logic [7:0] m11_seq[]   = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80,
                                8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h02};
`else
    logic [7:0] m11_seq[]   = '{8'h02, 8'h02, 8'h02, 8'h02};
`endif
    logic [7:0] pre_seq[]   = '{8'h80, 8'h40, 8'h20};
    int g;

    // Reset with enable low.
    reset = 1'b1; bus.enable = 1'b0; bus.mode = 2'b00; bus.step_div = 8'd0;
    @(posedge clk);
    @(negedge clk);
    check("reset_leds", 32'(bus.leds), 32'h10);
    check("reset_pulse", 32'(bus.step_pulse), 32'd0);
    chk_en = 1'b1;
    reset = 1'b0;
    repeat (10) @(negedge clk);
    check("idle_leds", 32'(bus.leds), 32'h10);

    // Calm blink every cycle.
    bus.enable = 1'b1;
    expect_steps("calm", calm_seq, 1);

    // Left-to-right sweep, one step every 3 cycles.
    bus.mode = 2'b10; bus.step_div = 8'd2;
    expect_steps("sweep", sweep_seq, 3);

    // Mode change mid-sweep restarts at the right end.
    bus.mode = 2'b01;
    expect_steps("rtol", rtol_seq, 3);

    // Mode 11: bounce or hold depending on build.
    bus.mode = 2'b11; bus.step_div = 8'd0;
    expect_steps("mode11", m11_seq, 1);

    // Reset in the middle of a sweep.
    bus.mode = 2'b10;
    expect_steps("pre_reset", pre_seq, 1);
    reset = 1'b1;
    @(negedge clk);
    check("midreset_leds", 32'(bus.leds), 32'h10);
    check("midreset_pulse", 32'(bus.step_pulse), 32'd0);
    reset = 1'b0;

    // Lower step_div below the running count.
    bus.step_div = 8'd7;
    repeat (5) @(negedge clk);
    check("cnt5_leds", 32'(bus.leds), 32'h10);
    check("cnt5_pulse", 32'(bus.step_pulse), 32'd0);
    bus.step_div = 8'd1;
    @(negedge clk);
    check("lower_div_leds", 32'(bus.leds), 32'h80);
    check("lower_div_pulse", 32'(bus.step_pulse), 32'd1);

    // Freeze with enable low.
    bus.enable = 1'b0;
    repeat (6) begin
      @(negedge clk);
      check("freeze_leds", 32'(bus.leds), 32'h80);
      check("freeze_pulse", 32'(bus.step_pulse), 32'd0);
    end

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
